// File: rtl/param_right_rotator_pipe.sv
// Pipelined right barrel rotator on 2**N-bit words: one register stage per
// log2 rotate level, with a single global stall driven by the output handshake.
module param_right_rotator_pipe #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2**N-1:0]   in_data,
    input  logic [N-1:0]      in_amt,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [2**N-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int W = 2**N;

    logic [W-1:0] r_data [1:N];
    logic [N-1:0] r_amt  [1:N];
    logic [N:1]   r_v;

    logic [W-1:0] w_nxt_data [1:N];
    logic [N-1:0] w_nxt_amt  [1:N];
    logic [N:1]   w_nxt_v;
    logic         w_adv;

    function automatic logic [W-1:0] rotr_pow2(input logic [W-1:0] d, input int sh);
        return (d >> sh) | (d << (W - sh));
    endfunction

    // Stage i rotates right by 2**(i-1) when bit i-1 of its carried amount is set.
    always_comb begin
        w_nxt_data[1] = in_amt[0] ? rotr_pow2(in_data, 1) : in_data;
        w_nxt_amt[1]  = in_amt;
        w_nxt_v[1]    = in_valid;
        for (int i = 2; i <= N; i++) begin
            w_nxt_data[i] = r_amt[i-1][i-1] ? rotr_pow2(r_data[i-1], 1 << (i-1))
                                            : r_data[i-1];
            w_nxt_amt[i]  = r_amt[i-1];
            w_nxt_v[i]    = r_v[i-1];
        end
    end

    // A bubble at the output lets the pipe advance even while the consumer stalls.
    assign w_adv = out_ready | ~r_v[N];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i <= N; i++) begin
                r_data[i] <= '0;
                r_amt[i]  <= '0;
            end
            r_v <= '0;
        end else if (w_adv) begin
            for (int i = 1; i <= N; i++) begin
                r_data[i] <= w_nxt_data[i];
                r_amt[i]  <= w_nxt_amt[i];
            end
            r_v <= w_nxt_v;
        end
    end

    assign in_ready  = w_adv;
    assign out_data  = r_data[N];
    assign out_valid = r_v[N];

endmodule
